// File: rtl/r4_twiddle_sched.sv
// r4_twiddle_sched: twiddle ROM address, bypass and valid-delay scheduler for one radix-4 MDC stage
module r4_twiddle_sched #(
    parameter int N        = 64,
    parameter int L        = 64,
    parameter int MULT_LAT = 3,
    parameter int AW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          flush,
    input  logic          in_valid,
    output logic          rom_en,
    output logic [AW-1:0] tw_addr1,
    output logic [AW-1:0] tw_addr2,
    output logic [AW-1:0] tw_addr3,
    output logic [3:0]    bypass,
    output logic          out_valid,
    output logic          frame_done,
    output logic          busy
);
    localparam int D  = 1 + MULT_LAT;
    localparam int CW = (L > 4) ? $clog2(L / 4) : 1;
    localparam logic [CW-1:0] NLAST = CW'(L / 4 - 1);
    localparam logic [AW-1:0] S1 = AW'(N / L);
    localparam logic [AW-1:0] S2 = AW'(2 * (N / L));
    localparam logic [AW-1:0] S3 = AW'(3 * (N / L));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] n_q;
    logic [AW-1:0] acc1_q, acc2_q, acc3_q;
    logic [3:0]    bypass_q;
    logic          frame_done_q;
    logic [D-1:0]  dl_q, dl_d;
    logic          accept, last;

    assign accept     = in_valid & (state_q == RUN);
    assign last       = n_q == NLAST;
    assign dl_d       = {dl_q[D-2:0], accept};
    assign rom_en     = accept;
    assign tw_addr1   = acc1_q;
    assign tw_addr2   = acc2_q;
    assign tw_addr3   = acc3_q;
    assign bypass     = bypass_q;
    assign out_valid  = dl_q[D-1];
    assign frame_done = frame_done_q;
    assign busy       = state_q != IDLE;

    // Next state: drain ends once nothing remains in flight after this edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = flush ? DRAIN : RUN;
            DRAIN:   state_d = (dl_d == '0) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // State, sample counter, per-lane accumulators, bypass flags and valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            acc1_q       <= '0;
            acc2_q       <= '0;
            acc3_q       <= '0;
            bypass_q     <= 4'b0001;
            frame_done_q <= 1'b0;
            dl_q         <= '0;
        end else begin
            state_q      <= state_d;
            dl_q         <= dl_d;
            frame_done_q <= accept & last;
            if (state_q == IDLE && start) begin
                n_q    <= '0;
                acc1_q <= '0;
                acc2_q <= '0;
                acc3_q <= '0;
            end else if (accept) begin
                n_q    <= last ? '0 : n_q + CW'(1);
                acc1_q <= last ? '0 : acc1_q + S1;
                acc2_q <= last ? '0 : acc2_q + S2;
                acc3_q <= last ? '0 : acc3_q + S3;
            end
            if (accept)
                bypass_q <= {acc3_q == '0, acc2_q == '0, acc1_q == '0, 1'b1};
        end
    end
endmodule

// File: tb/tb_r4_twiddle_sched.sv
// tb_r4_twiddle_sched: directed checks of the twiddle scheduler for L=64 and L=16 stages
module tb_r4_twiddle_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       rom_en, out_valid, frame_done, busy;
    logic [5:0] a1, a2, a3;
    logic [3:0] byp;
    logic       rom_en16, out_valid16, frame_done16, busy16;
    logic [5:0] b1, b2, b3;
    logic [3:0] byp16;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    r4_twiddle_sched #(.N(64), .L(64), .MULT_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .in_valid(in_valid),
        .rom_en(rom_en), .tw_addr1(a1), .tw_addr2(a2), .tw_addr3(a3), .bypass(byp),
        .out_valid(out_valid), .frame_done(frame_done), .busy(busy)
    );

    r4_twiddle_sched #(.N(64), .L(16), .MULT_LAT(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .in_valid(in_valid),
        .rom_en(rom_en16), .tw_addr1(b1), .tw_addr2(b2), .tw_addr3(b3), .bypass(byp16),
        .out_valid(out_valid16), .frame_done(frame_done16), .busy(busy16)
    );

    // Drive one cycle's inputs mid-cycle, then let combinational outputs settle
    task automatic cyc(input logic s, input logic f, input logic v);
        @(negedge clk);
        start = s;
        flush = f;
        in_valid = v;
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            cyc(0, 0, 0);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s drain timeout: busy=%b required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 0; flush = 0; in_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({rom_en, a1, a2, a3, byp, out_valid, frame_done, busy} !== {1'b0, 18'd0, 4'b0001, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: rom_en=%b a=%0d/%0d/%0d byp=%b ov=%b fd=%b busy=%b required 0 0/0/0 0001 0 0 0",
                     rom_en, a1, a2, a3, byp, out_valid, frame_done, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_frame64();
        logic [5:0] k6;
        test_reset();
        cyc(1, 0, 0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_start_cycle: %b required 0", busy); end
        for (int k = 0; k < 16; k++) begin
            cyc(0, 0, 1);
            k6 = 6'(k);
            checks++;
            if (rom_en !== 1'b1 || a1 !== k6 || a2 !== 6'(2 * k) || a3 !== 6'(3 * k)) begin
                errors++;
                $display("FAIL frame64_addr n=%0d: rom_en=%b a=%0d/%0d/%0d required 1 %0d/%0d/%0d",
                         k, rom_en, a1, a2, a3, k, 2 * k, 3 * k);
            end
            checks++;
            if (byp !== ((k == 1) ? 4'b1111 : 4'b0001)) begin
                errors++;
                $display("FAIL frame64_bypass cycle=%0d: %b required %b", k, byp, (k == 1) ? 4'b1111 : 4'b0001);
            end
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b1 || out_valid !== (k >= 4)) begin
                errors++;
                $display("FAIL frame64_ctl cycle=%0d: fd=%b busy=%b ov=%b required 0 1 %b", k, frame_done, busy, out_valid, k >= 4);
            end
        end
        cyc(0, 0, 0);
        checks++;
        if (frame_done !== 1'b1 || byp !== 4'b0001 || rom_en !== 1'b0 || {a1, a2, a3} !== 18'd0) begin
            errors++;
            $display("FAIL frame64_end: fd=%b byp=%b rom_en=%b a=%0d/%0d/%0d required 1 0001 0 0/0/0",
                     frame_done, byp, rom_en, a1, a2, a3);
        end
        cyc(0, 0, 0);
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL frame64_done_pulse: fd=%b required 0", frame_done); end
        cyc(0, 1, 0);
        wait_idle("frame64");
    endtask

    task automatic test_frame16();
        int fd_cnt;
        test_reset();
        cyc(1, 0, 0);
        fd_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 1);
            if (frame_done16 === 1'b1) fd_cnt++;
            checks++;
            if (b3 !== 6'((k % 4) * 12) || b2 !== 6'((k % 4) * 8) || b1 !== 6'((k % 4) * 4)) begin
                errors++;
                $display("FAIL frame16_addr k=%0d: a=%0d/%0d/%0d required %0d/%0d/%0d",
                         k, b1, b2, b3, (k % 4) * 4, (k % 4) * 8, (k % 4) * 12);
            end
            if (k == 4) begin
                checks++;
                if (frame_done16 !== 1'b1) begin errors++; $display("FAIL frame16_first_done: fd=%b required 1", frame_done16); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0);
            if (frame_done16 === 1'b1) fd_cnt++;
        end
        checks++;
        if (fd_cnt != 2) begin errors++; $display("FAIL frame16_done_count: %0d required 2", fd_cnt); end
        cyc(0, 1, 0);
        wait_idle("frame16");
    endtask

    task automatic test_gaps();
        logic [3:0] pat;
        logic [5:0] exp_a1;
        logic       v;
        pat = 4'b1101;
        exp_a1 = 6'd0;
        test_reset();
        cyc(1, 0, 0);
        for (int c = 0; c < 12; c++) begin
            v = (c < 4) ? pat[c] : 1'b0;
            cyc(0, 0, v);
            if (c < 4) begin
                checks++;
                if (a1 !== exp_a1 || rom_en !== v) begin
                    errors++;
                    $display("FAIL gaps_addr cycle=%0d: a1=%0d rom_en=%b required %0d %b", c, a1, rom_en, exp_a1, v);
                end
                if (v) exp_a1 = exp_a1 + 6'd1;
            end
            checks++;
            if (out_valid !== ((c >= 4 && c < 8) ? pat[c - 4] : 1'b0)) begin
                errors++;
                $display("FAIL gaps_out_valid cycle=%0d: %b required %b", c, out_valid, (c >= 4 && c < 8) ? pat[c - 4] : 1'b0);
            end
        end
        cyc(0, 1, 0);
        wait_idle("gaps");
    endtask

    task automatic test_flush();
        logic fd_seen;
        fd_seen = 1'b0;
        test_reset();
        cyc(1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1);
            fd_seen |= frame_done;
        end
        cyc(0, 1, 1);
        checks++;
        if (rom_en !== 1'b1 || a1 !== 6'd5) begin
            errors++;
            $display("FAIL flush_accept: rom_en=%b a1=%0d required 1 5", rom_en, a1);
        end
        for (int c = 6; c < 13; c++) begin
            cyc(0, 0, 1);
            fd_seen |= frame_done;
            checks++;
            if (rom_en !== 1'b0 || out_valid !== (c <= 9) || busy !== (c <= 9)) begin
                errors++;
                $display("FAIL flush_drain cycle=%0d: rom_en=%b ov=%b busy=%b required 0 %b %b",
                         c, rom_en, out_valid, busy, c <= 9, c <= 9);
            end
        end
        checks++;
        if (fd_seen !== 1'b0) begin errors++; $display("FAIL flush_no_done: fd seen=%b required 0", fd_seen); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        test_reset();
        cyc(1, 0, 0);
        for (int k = 0; k < 7; k++) cyc(0, 0, 1);
        cyc(0, 0, 1);
        checks++;
        if (a1 !== 6'd7) begin errors++; $display("FAIL rstmid_pre: a1=%0d required 7", a1); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_en, a1, a2, a3, byp, out_valid, frame_done, busy} !== {1'b0, 18'd0, 4'b0001, 3'b000}) begin
            errors++;
            $display("FAIL rstmid_async: rom_en=%b a=%0d/%0d/%0d byp=%b ov=%b fd=%b busy=%b required 0 0/0/0 0001 0 0 0",
                     rom_en, a1, a2, a3, byp, out_valid, frame_done, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid k=%0d: %b required 0", k, out_valid); end
        end
    endtask

    task automatic test_ignored();
        test_reset();
        cyc(1, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 1);
        cyc(1, 0, 1);
        checks++;
        if (a1 !== 6'd3) begin errors++; $display("FAIL ign_start_in_run: a1=%0d required 3", a1); end
        cyc(0, 0, 1);
        checks++;
        if (a1 !== 6'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_start_follow: a1=%0d busy=%b required 4 1", a1, busy);
        end
        cyc(0, 1, 0);
        wait_idle("ignored");
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_flush_in_idle: busy=%b required 0", busy); end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1);
            checks++;
            if (rom_en !== 1'b0) begin errors++; $display("FAIL ign_valid_idle_rom k=%0d: %b required 0", k, rom_en); end
        end
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ign_valid_idle_out k=%0d: ov=%b busy=%b required 0 0", k, out_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame64();
        test_frame16();
        test_gaps();
        test_flush();
        test_reset_mid();
        test_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/r4_twiddle_sched.md
# r4_twiddle_sched

Twiddle-factor scheduler for one radix-4 MDC stage. It counts accepted butterfly outputs, generates the per-lane twiddle ROM addresses, and flags trivial (W^0 = 1) twiddles so the complex-multiplier lanes can be bypassed. It also delays the sample-valid strobe to match the ROM plus complex-multiplier latency. It sits between the stage's radix-4 butterfly and the three complex-multiplier lanes (lanes 1..3; lane 0 is never multiplied).

## Interface
- N, 64: total FFT size; power of 4, at least 16.
- L, 64: length of this stage's sub-transform; power of 4, 4 ≤ L ≤ N.
- MULT_LAT, 3: complex-multiplier latency in clk cycles, at least 1.
- AW, $clog2(N): twiddle ROM address width.

Ports:
- clk  in  1  clock; all registers use the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run. Acted on only in IDLE.
- flush  in  1  one-cycle pulse that ends a run. Acted on only in RUN.
- in_valid  in  1  butterfly output valid, all 4 lanes together.
- rom_en  out  1  twiddle ROM read enable.
- tw_addr1  out  AW  lane-1 twiddle address.
- tw_addr2  out  AW  lane-2 twiddle address.
- tw_addr3  out  AW  lane-3 twiddle address.
- bypass  out  4  per-lane trivial-twiddle flag, aligned with ROM data.
- out_valid  out  1  multiplier output valid.
- frame_done  out  1  one-cycle pulse after the last sample of each L-point block.
- busy  out  1  high in RUN and DRAIN.

## Operation
- FSM states are IDLE, RUN and DRAIN.
  - IDLE -> RUN on start. Entering RUN clears the counter and all accumulators.
  - RUN -> DRAIN on flush.
  - DRAIN -> IDLE when the valid delay line is all zero.
- accept = in_valid & (state == RUN). in_valid is ignored in IDLE and DRAIN.
- Sample counter n counts 0 .. L/4-1 and advances on each accept.
- Per-lane accumulators acc_l, for l = 1..3, are AW bits wide and arithmetic on them is modulo N (natural wrap).
  - On accept, acc_l += l*(N/L).
  - On an accept where n == L/4-1, n and all acc_l return to 0.
  - Resulting address: tw_addr_l = (l*n*N/L) mod N.
- The address outputs are driven directly from the accumulators: tw_addr_l = acc_l. The addresses present in a cycle belong to the sample accepted in that cycle.
- rom_en = accept. This output is combinational.
- bypass is registered on accept:
  - bit 0 = 1;
  - bit l = (acc_l == 0), for l = 1..3.
  - bypass holds its value between accepts.
- frame_done is registered high for one cycle, in the cycle after the accept where n == L/4-1.
- Valid delay line: a shift register of depth 1+MULT_LAT, fed by accept. out_valid is its last stage.
- flush accompanied by in_valid in the same cycle: the sample is accepted, then the FSM goes to DRAIN.
- start outside IDLE is ignored. flush outside RUN is ignored.
- A partial frame cut short by flush produces no frame_done. The next start clears the counter and accumulators.

## Timing
- Reset values: state IDLE; n = 0; acc_l = 0; tw_addr1..3 = 0; rom_en = 0; bypass = 4'b0001; out_valid = 0; frame_done = 0; busy = 0. The delay line is cleared.
- Reset applied mid-run returns to these values immediately and asynchronously. In-flight valids are discarded.
- Cycle timing relative to an accept in cycle t:
  - ROM data and bypass are valid at t+1.
  - out_valid is asserted at t+1+MULT_LAT.
  - frame_done is asserted at t+1 (when applicable).
- Throughput is one sample per cycle; back-to-back accepts are supported without stall.
- busy rises the cycle after start.
- DRAIN lasts at most 1+MULT_LAT cycles. busy falls in the cycle the FSM enters IDLE.
- The IDLE -> RUN and RUN -> DRAIN transitions take effect on the next clock edge.

## Test plan
- Configuration N=64, L=64, MULT_LAT=3, start followed by 16 back-to-back in_valid:
  - for n = 0..15, addresses are (n, 2n, 3n);
  - at n = 15, addresses are (15, 30, 45);
  - bypass is 4'b1111 for n = 0 and 4'b0001 otherwise;
  - frame_done pulses once, one cycle after the 16th accept.
- Configuration N=64, L=16, 8 accepts:
  - lane-3 addresses are 0, 12, 24, 36, then 0, 12, 24, 36;
  - lane-2 addresses are 0, 8, 16, 24, repeated;
  - frame_done pulses twice.
- Latency and gaps, MULT_LAT=3, in_valid pattern 1,0,1,1:
  - out_valid repeats the same 1,0,1,1 pattern, starting exactly 4 cycles later;
  - the counter does not advance on the gap cycle.
- Flush mid-frame after 5 accepts, with in_valid held high:
  - the sample in the flush cycle is accepted;
  - the FSM enters DRAIN and no further rom_en is asserted;
  - busy falls after the last out_valid;
  - no frame_done is produced.
- Reset mid-run at n = 7: all outputs return to their reset values asynchronously, and out_valid stays 0 afterwards.
- Ignored controls:
  - start pulsed in RUN leaves the counter unchanged;
  - flush pulsed in IDLE leaves busy at 0;
  - in_valid asserted in IDLE produces no rom_en and no out_valid.
